// File: rtl/spi_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// spi_cmd_sequencer
//
// Framed command controller between the SPI byte receiver and the
// servo/LED worker. It collects 4-byte frames (SYNC, CMD, ARG, CHK) from the
// received byte stream. CHK must equal CMD ^ ARG. It then executes the
// command: a throttled trigger pulse, a clamped servo position or a LED
// override mask. Rejected frames are counted in a saturating error counter.
//
// Parameters
//   SYNC_BYTE    frame start marker
//   TIMEOUT_CYC  max clk cycles between bytes inside a frame
//   SERVO_MAX    upper clamp for the servo position argument
//
// Ports
//   clk            in   system clock
//   rst            in   synchronous, active-high reset
//   rx_data[7:0]   in   received byte, valid when rx_valid=1
//   rx_valid       in   one-cycle strobe per received byte
//   worker_busy    in   worker still executing the previous trigger
//   trigger        out  one-cycle start pulse to the worker
//   servo_pos[7:0] out  commanded servo position, 0..SERVO_MAX
//   servo_pos_upd  out  one-cycle pulse when servo_pos changes value
//   led_mask[1:0]  out  [0]=green override, [1]=red override
//   frame_ok       out  one-cycle pulse per accepted frame
//   frame_err      out  one-cycle pulse per rejected frame
//   err_cnt[7:0]   out  saturating count of frame_err pulses
// ----------------------------------------------------------------------------
module spi_cmd_sequencer #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 250000,
    parameter logic [7:0] SERVO_MAX   = 8'd180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       worker_busy,
    output logic       trigger,
    output logic [7:0] servo_pos,
    output logic       servo_pos_upd,
    output logic [1:0] led_mask,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [7:0] err_cnt
);

    localparam logic [7:0] CMD_TRIG  = 8'hA1;
    localparam logic [7:0] CMD_SERVO = 8'h10;
    localparam logic [7:0] CMD_LED   = 8'h20;

    localparam logic [7:0] SERVO_RST = 8'd90;

    localparam int              TO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_CMD,
        S_GET_ARG,
        S_GET_CHK,
        S_EXEC
    } state_t;

    // Servo argument limited to the mechanical range.
    function automatic logic [7:0] clamp_servo(input logic [7:0] a);
        return (a > SERVO_MAX) ? SERVO_MAX : a;
    endfunction

    // Error counter increments stick at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t          r_state;
    logic [TO_W-1:0] r_to_cnt;
    logic [7:0]      r_cmd;
    logic [7:0]      r_arg;
    logic            r_pending;
    logic            r_trigger;
    logic [7:0]      r_servo_pos;
    logic            r_servo_pos_upd;
    logic [1:0]      r_led_mask;
    logic            r_frame_ok;
    logic            r_frame_err;
    logic [7:0]      r_err_cnt;

    logic       w_in_frame;
    logic       w_start;
    logic       w_chk_good;
    logic       w_timeout;
    logic       w_cmd_known;
    logic       w_err_set;
    logic       w_exec_trig;
    logic [7:0] w_servo_new;

    assign w_in_frame  = (r_state == S_GET_CMD) || (r_state == S_GET_ARG) ||
                         (r_state == S_GET_CHK);
    // A SYNC byte starts a frame both in IDLE and in the EXEC cycle, so
    // back-to-back frames lose no byte.
    assign w_start     = rx_valid && (rx_data == SYNC_BYTE);
    assign w_chk_good  = (rx_data == (r_cmd ^ r_arg));
    // A byte arriving on the last counted cycle wins over the timeout.
    assign w_timeout   = w_in_frame && !rx_valid && (r_to_cnt == TO_LAST);
    assign w_cmd_known = (r_cmd == CMD_TRIG) || (r_cmd == CMD_SERVO) ||
                         (r_cmd == CMD_LED);
    assign w_err_set   = ((r_state == S_GET_CHK) && rx_valid && !w_chk_good) ||
                         w_timeout ||
                         ((r_state == S_EXEC) && !w_cmd_known);
    assign w_exec_trig = (r_state == S_EXEC) && (r_cmd == CMD_TRIG);
    assign w_servo_new = clamp_servo(r_arg);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_to_cnt        <= '0;
            r_pending       <= 1'b0;
            r_trigger       <= 1'b0;
            r_servo_pos     <= SERVO_RST;
            r_servo_pos_upd <= 1'b0;
            r_led_mask      <= 2'b00;
            r_frame_ok      <= 1'b0;
            r_frame_err     <= 1'b0;
            r_err_cnt       <= 8'd0;
        end else begin
            r_trigger       <= 1'b0;
            r_servo_pos_upd <= 1'b0;
            r_frame_ok      <= 1'b0;
            r_frame_err     <= w_err_set;
            if (w_err_set) begin
                r_err_cnt <= sat_inc8(r_err_cnt);
            end

            // Inter-byte timer: only counts while a frame is partially received.
            if (!w_in_frame || rx_valid || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_GET_CMD;
                    end
                end
                S_GET_CMD: begin
                    if (rx_valid) begin
                        r_cmd   <= rx_data;
                        r_state <= S_GET_ARG;
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
                S_GET_ARG: begin
                    if (rx_valid) begin
                        r_arg   <= rx_data;
                        r_state <= S_GET_CHK;
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
                S_GET_CHK: begin
                    if (rx_valid) begin
                        r_state <= w_chk_good ? S_EXEC : S_IDLE;
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    r_state <= w_start ? S_GET_CMD : S_IDLE;
                    case (r_cmd)
                        CMD_TRIG: begin
                            r_frame_ok <= 1'b1;
                        end
                        CMD_SERVO: begin
                            r_servo_pos     <= w_servo_new;
                            r_servo_pos_upd <= (w_servo_new != r_servo_pos);
                            r_frame_ok      <= 1'b1;
                        end
                        CMD_LED: begin
                            r_led_mask <= r_arg[1:0];
                            r_frame_ok <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Trigger throttle. Consuming pending takes priority over a new
            // request in the same cycle, which merges that request; pending
            // is clear during the trigger-high cycle, so trigger can never
            // be high on two consecutive cycles.
            if (r_pending && !worker_busy) begin
                r_trigger <= 1'b1;
                r_pending <= 1'b0;
            end else if (w_exec_trig) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign trigger       = r_trigger;
    assign servo_pos     = r_servo_pos;
    assign servo_pos_upd = r_servo_pos_upd;
    assign led_mask      = r_led_mask;
    assign frame_ok      = r_frame_ok;
    assign frame_err     = r_frame_err;
    assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_spi_cmd_sequencer
//
// Directed bench for spi_cmd_sequencer: a table of whole frames with their
// expected pulse counts and resulting output values, followed by hand-written
// sequences for trigger latency, busy throttling, back-to-back frames,
// IDLE garbage, inter-byte timeout, error saturation and reset mid-frame.
// Inputs are driven on the falling edge, and outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_spi_cmd_sequencer;

    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       worker_busy;
    logic       trigger;
    logic [7:0] servo_pos;
    logic       servo_pos_upd;
    logic [1:0] led_mask;
    logic       frame_ok;
    logic       frame_err;
    logic [7:0] err_cnt;

    spi_cmd_sequencer #(
        .SYNC_BYTE  (8'hA5),
        .TIMEOUT_CYC(TO),
        .SERVO_MAX  (8'd180)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .worker_busy  (worker_busy),
        .trigger      (trigger),
        .servo_pos    (servo_pos),
        .servo_pos_upd(servo_pos_upd),
        .led_mask     (led_mask),
        .frame_ok     (frame_ok),
        .frame_err    (frame_err),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    // Cumulative pulse counters, updated once per cycle.
    int   n_ok = 0, n_err = 0, n_upd = 0, n_trg = 0, n_consec = 0;
    logic prev_trg = 1'b0;

    always @(negedge clk) begin
        n_ok  += int'(frame_ok);
        n_err += int'(frame_err);
        n_upd += int'(servo_pos_upd);
        n_trg += int'(trigger);
        if (trigger && prev_trg) n_consec++;
        prev_trg = trigger;
    end

    int n_assert = 0;
    int n_fail   = 0;
    int b_ok, b_err, b_upd, b_trg;

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic snap();
        b_ok  = n_ok;
        b_err = n_err;
        b_upd = n_upd;
        b_trg = n_trg;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        string      nm;
        logic [7:0] b0, b1, b2, b3;
        int         ok, err, upd, trg;
        logic [7:0] servo;
        logic [1:0] led;
        logic [7:0] ecnt;
    } vec_t;

    function automatic vec_t mk(input string nm,
                                input logic [7:0] b0, b1, b2, b3,
                                input int ok, err, upd, trg,
                                input logic [7:0] servo, input logic [1:0] led,
                                input logic [7:0] ecnt);
        vec_t v;
        v.nm = nm; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.b3 = b3;
        v.ok = ok; v.err = err; v.upd = upd; v.trg = trg;
        v.servo = servo; v.led = led; v.ecnt = ecnt;
        return v;
    endfunction

    vec_t vecs[13];

    initial begin
        int trace;
        int k;

        // Frames applied in order from reset; expectations are cumulative.
        //                    bytes                         ok err upd trg servo    led    ecnt
        vecs[0]  = mk("trig",       8'hA5, 8'hA1, 8'h00, 8'hA1, 1, 0, 0, 1, 8'd90,  2'd0, 8'd0);
        vecs[1]  = mk("servo200",   8'hA5, 8'h10, 8'hC8, 8'hD8, 1, 0, 1, 0, 8'd180, 2'd0, 8'd0);
        vecs[2]  = mk("servo180s",  8'hA5, 8'h10, 8'hB4, 8'hA4, 1, 0, 0, 0, 8'd180, 2'd0, 8'd0);
        vecs[3]  = mk("led_badchk", 8'hA5, 8'h20, 8'h03, 8'hFF, 0, 1, 0, 0, 8'd180, 2'd0, 8'd1);
        vecs[4]  = mk("led3",       8'hA5, 8'h20, 8'h03, 8'h23, 1, 0, 0, 0, 8'd180, 2'd3, 8'd1);
        vecs[5]  = mk("servo45",    8'hA5, 8'h10, 8'h2D, 8'h3D, 1, 0, 1, 0, 8'd45,  2'd3, 8'd1);
        vecs[6]  = mk("servo181",   8'hA5, 8'h10, 8'hB5, 8'hA5, 1, 0, 1, 0, 8'd180, 2'd3, 8'd1);
        vecs[7]  = mk("servo180",   8'hA5, 8'h10, 8'hB4, 8'hA4, 1, 0, 0, 0, 8'd180, 2'd3, 8'd1);
        vecs[8]  = mk("led_hiarg",  8'hA5, 8'h20, 8'hFE, 8'hDE, 1, 0, 0, 0, 8'd180, 2'd2, 8'd1);
        vecs[9]  = mk("unk_cmd",    8'hA5, 8'h33, 8'h01, 8'h32, 0, 1, 0, 0, 8'd180, 2'd2, 8'd2);
        vecs[10] = mk("cmd_sync",   8'hA5, 8'hA5, 8'h00, 8'hA5, 0, 1, 0, 0, 8'd180, 2'd2, 8'd3);
        vecs[11] = mk("servo0",     8'hA5, 8'h10, 8'h00, 8'h10, 1, 0, 1, 0, 8'd0,   2'd2, 8'd3);
        vecs[12] = mk("servo0s",    8'hA5, 8'h10, 8'h00, 8'h10, 1, 0, 0, 0, 8'd0,   2'd2, 8'd3);

        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; worker_busy = 1'b0;
        wait_neg(3);
        rst = 1'b0;

        // Reset state
        chk("rst_trigger", int'(trigger), 0);
        chk("rst_servo",   int'(servo_pos), 90);
        chk("rst_upd",     int'(servo_pos_upd), 0);
        chk("rst_led",     int'(led_mask), 0);
        chk("rst_ok",      int'(frame_ok), 0);
        chk("rst_err",     int'(frame_err), 0);
        chk("rst_errcnt",  int'(err_cnt), 0);

        // Table-driven frames
        for (int i = 0; i < 13; i++) begin
            snap();
            send_frame(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
            wait_neg(6);
            chk({vecs[i].nm, "_ok"},    n_ok  - b_ok,  vecs[i].ok);
            chk({vecs[i].nm, "_err"},   n_err - b_err, vecs[i].err);
            chk({vecs[i].nm, "_upd"},   n_upd - b_upd, vecs[i].upd);
            chk({vecs[i].nm, "_trg"},   n_trg - b_trg, vecs[i].trg);
            chk({vecs[i].nm, "_servo"}, int'(servo_pos), int'(vecs[i].servo));
            chk({vecs[i].nm, "_led"},   int'(led_mask),  int'(vecs[i].led));
            chk({vecs[i].nm, "_ecnt"},  int'(err_cnt),   int'(vecs[i].ecnt));
        end

        // Trigger latency: CHK byte in cycle N, trigger high only in cycle N+3.
        trace = 0;
        send_frame(8'hA5, 8'hA1, 8'h00, 8'hA1);
        for (int j = 0; j < 5; j++) begin
            if (trigger) trace |= (1 << j);
            @(negedge clk);
        end
        chk("trig_latency", trace, 32'h4);

        // Back-to-back frames: second SYNC lands in the EXEC cycle.
        snap();
        send_frame(8'hA5, 8'hA1, 8'h00, 8'hA1);
        send_frame(8'hA5, 8'hA1, 8'h00, 8'hA1);
        wait_neg(8);
        chk("b2b_ok",  n_ok  - b_ok,  2);
        chk("b2b_trg", n_trg - b_trg, 2);

        // Busy throttle: two requests merge into one trigger after busy drops.
        snap();
        worker_busy = 1'b1;
        send_frame(8'hA5, 8'hA1, 8'h00, 8'hA1);
        send_frame(8'hA5, 8'hA1, 8'h00, 8'hA1);
        wait_neg(10);
        chk("busy_ok",      n_ok  - b_ok,  2);
        chk("busy_trg",     n_trg - b_trg, 0);
        worker_busy = 1'b0;
        wait_neg(6);
        chk("busy_rel_trg", n_trg - b_trg, 1);
        wait_neg(6);
        chk("busy_one_trg", n_trg - b_trg, 1);

        // Non-SYNC bytes in IDLE are dropped silently.
        snap();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h11);
        send_byte(8'hA1);
        wait_neg(4);
        chk("junk_ok",  n_ok  - b_ok,  0);
        chk("junk_err", n_err - b_err, 0);
        chk("junk_trg", n_trg - b_trg, 0);

        // Inter-byte timeout: frame_err appears TO+1 samples after the last byte.
        snap();
        send_byte(8'hA5);
        send_byte(8'h10);
        k = 1;
        while (!frame_err && k < 3 * TO) begin
            @(negedge clk);
            k++;
        end
        if (!frame_err) k = 0;
        chk("timeout_lat", k, TO + 1);
        wait_neg(2);
        chk("timeout_err",  n_err - b_err, 1);
        chk("timeout_ecnt", int'(err_cnt), 4);
        snap();
        send_frame(8'hA5, 8'h20, 8'h01, 8'h21);
        wait_neg(4);
        chk("after_to_ok",  n_ok - b_ok, 1);
        chk("after_to_led", int'(led_mask), 1);

        // Error counter saturation.
        snap();
        for (int i = 0; i < 300; i++) send_frame(8'hA5, 8'h20, 8'h03, 8'h00);
        wait_neg(3);
        chk("sat_err",  n_err - b_err, 300);
        chk("sat_ecnt", int'(err_cnt), 255);

        // Reset mid-frame with a pending trigger held off by busy.
        worker_busy = 1'b1;
        send_frame(8'hA5, 8'hA1, 8'h00, 8'hA1);
        wait_neg(4);
        send_byte(8'hA5);
        send_byte(8'h10);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_trigger", int'(trigger), 0);
        chk("mrst_servo",   int'(servo_pos), 90);
        chk("mrst_upd",     int'(servo_pos_upd), 0);
        chk("mrst_led",     int'(led_mask), 0);
        chk("mrst_ok",      int'(frame_ok), 0);
        chk("mrst_err",     int'(frame_err), 0);
        chk("mrst_errcnt",  int'(err_cnt), 0);
        rst = 1'b0;
        snap();
        worker_busy = 1'b0;
        wait_neg(8);
        chk("mrst_pend_drop", n_trg - b_trg, 0);
        snap();
        send_frame(8'hA5, 8'h10, 8'h3C, 8'h2C);
        wait_neg(4);
        chk("post_rst_ok",    n_ok - b_ok, 1);
        chk("post_rst_servo", int'(servo_pos), 60);
        chk("post_rst_upd",   n_upd - b_upd, 1);
        chk("post_rst_ecnt",  int'(err_cnt), 0);

        chk("no_consec_trig", n_consec, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
